best_match_tracker: RTL and testbench
=====================================

Name: best_match_tracker

Overview:
- Downstream stage of the Levenshtein engine. Consumes its per-word distance stream and tracks, per search, the best (minimum) distance, the index of the word that produced it, and the number of words at or under a threshold.
- On request, it serialises a snapshot of these results as a byte stream that the SPI controller forwards to the host.

Parameters:
- INDEX_WIDTH, 16, width of the word index and match counter. Legal values are 8, 16 and 24, so it is always a multiple of 8.

Ports:
- aclk  input  1  clock.
- aresetn  input  1  reset; asynchronous assert, active-low.
- threshold  input  8  match threshold; sampled on each accepted input beat.
- s_axis_tvalid  input  1  distance beat valid. The block is always ready; there is no tready.
- s_axis_tdata  input  8  unsigned Levenshtein distance of the current dictionary word.
- s_axis_tuser  input  1  first beat of a new search.
- read_req  input  1  single-cycle pulse requesting a result frame.
- m_axis_tvalid  output  1  frame byte valid.
- m_axis_tready  input  1  downstream accepts the byte.
- m_axis_tdata  output  8  frame byte.
- m_axis_tlast  output  1  final byte of the frame.
- busy  output  1  frame transmission in progress.
- best_valid  output  1  at least one beat has been accepted since the last clear.

Behaviour:
- Clock and reset: one clock, aclk. Reset aresetn is asynchronous and active-low.
- Reset values:
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, busy=0, best_valid=0.
  - Internal: best_dist=8'hFF, best_idx=0, next_idx=0, match_cnt=0, overflow=0, FSM=IDLE.
- Accepted beat: s_axis_tvalid=1 at a rising edge.
- If tuser=1, the beat starts a new search. The beat is evaluated against cleared state:
  - best_valid=0, best_dist=FF, next_idx=0, match_cnt=0, overflow=0.
  - The beat then takes index 0.
- Per beat, with d=tdata and i=next_idx (evaluated after any clear):
  - Update the best when best_valid==0 or d<best_dist: best_dist<=d, best_idx<=i, best_valid<=1.
  - On equal distance (d==best_dist) the best is not updated; the first occurrence wins.
  - If d<=threshold, match_cnt<=match_cnt+1. It saturates at all-ones and sets overflow.
  - next_idx<=i+1. At all-ones, next_idx holds and overflow<=1; later beats reuse the max index.
- Results update 1 cycle after the beat. No backpressure; a beat is accepted every cycle.
- Read FSM states: IDLE, SEND.
- IDLE:
  - read_req=1 copies {best_valid, overflow, best_dist, best_idx, match_cnt} into the snapshot. The copy is the register values before that edge's beat; a beat in the same cycle is excluded.
  - Transition to SEND with byte_ptr=0.
  - m_axis_tvalid rises the following cycle, i.e. 1 cycle latency from read_req.
- SEND:
  - m_axis_tvalid=1 and busy=1.
  - m_axis_tdata is held stable until tready.
  - A handshake (tvalid&tready) advances byte_ptr.
- Frame layout (N = 2 + 2*INDEX_WIDTH/8 bytes; 6 for the default):
  - byte0 = {best_valid, overflow, 6'b0}.
  - byte1 = best_dist.
  - Then best_idx, little-endian.
  - Then match_cnt, little-endian.
- m_axis_tlast=1 only on byte N-1.
- The handshake on the last byte returns the FSM to IDLE. m_axis_tvalid=0 in the next cycle, so there are no back-to-back frames without a new read_req.
- read_req while in SEND is ignored and not queued.
- Input beats during SEND update the live registers only; the frame in flight is unaffected.
- Reset mid-frame: all outputs go to reset values immediately, without waiting for a clock edge. The partial frame is abandoned.

Optional Feature:
- Macro BEST_MATCH_TIE_LAST_EN.
- Defined: on equal distance (d==best_dist, best_valid=1) best_idx<=i, so the last occurrence wins.
- Undefined: equal distances leave the best unchanged (first occurrence wins).
- No other behaviour differs.

Test Plan:
- Reset, then read_req with no beats -> frame 00,FF,00,00,00,00 with tlast on byte5; best_valid=0.
- tuser beat d=5, then d=3, d=7, d=3, threshold=4, then read_req -> frame 80,03,01,00,02,00.
- As above with BEST_MATCH_TIE_LAST_EN defined -> frame 80,03,03,00,02,00.
- Frame in progress, m_axis_tready toggled 1,0,0,1,... -> each byte held stable while tready=0; exactly 6 handshakes; second read_req during SEND produces no extra frame.
- Mid-search new tuser beat d=9, threshold=2 -> frame 80,09,00,00,00,00. Previous search fully cleared.
- INDEX_WIDTH=8, 300 beats of d=1, threshold=1 -> byte0=C0, index saturates at FF, match_cnt=FF. aresetn pulsed during SEND -> m_axis_tvalid drops immediately.

Source files
------------

// File: rtl/best_match_tracker.sv
// Tracks the best (minimum) Levenshtein distance, its word index and the threshold match count,
// and serialises a snapshot as a byte frame. Optional macro BEST_MATCH_TIE_LAST_EN: on ties the last occurrence wins.
module best_match_tracker #(
  parameter int INDEX_WIDTH = 16
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic [7:0] threshold,
  input  logic       s_axis_tvalid,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tuser,
  input  logic       read_req,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tlast,
  output logic       busy,
  output logic       best_valid
);

  localparam int NBYTES  = 2 + 2 * INDEX_WIDTH / 8;
  localparam int FRAME_W = 8 * NBYTES;
  localparam int PTR_W   = 3;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                   state, state_nxt;
  logic [PTR_W-1:0]         byte_ptr;
  logic [FRAME_W-1:0]       snap;
  logic [FRAME_W-1:0]       snap_shift;
  logic [7:0]               best_dist;
  logic [INDEX_WIDTH-1:0]   best_idx, next_idx, match_cnt;
  logic                     overflow;

  logic                     cur_valid, cur_ovf;
  logic [7:0]               cur_dist;
  logic [INDEX_WIDTH-1:0]   cur_idx, cur_cnt;
  logic                     idx_max, cnt_max, hit, take_best, take_idx;
  logic                     last_byte, handshake;

  // A tuser beat is evaluated against cleared state, so substitute cleared values here.
  always_comb begin
    cur_valid = best_valid & ~s_axis_tuser;
    cur_ovf   = overflow & ~s_axis_tuser;
    cur_dist  = s_axis_tuser ? 8'hFF : best_dist;
    cur_idx   = s_axis_tuser ? '0 : next_idx;
    cur_cnt   = s_axis_tuser ? '0 : match_cnt;
    idx_max   = &cur_idx;
    cnt_max   = &cur_cnt;
    hit       = s_axis_tdata <= threshold;
    take_best = ~cur_valid | (s_axis_tdata < cur_dist);
`ifdef BEST_MATCH_TIE_LAST_EN
    take_idx  = take_best | (s_axis_tdata == cur_dist);
`else
    take_idx  = take_best;
`endif
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      best_valid <= 1'b0;
      best_dist  <= 8'hFF;
      best_idx   <= '0;
      next_idx   <= '0;
      match_cnt  <= '0;
      overflow   <= 1'b0;
    end else if (s_axis_tvalid) begin
      best_valid <= 1'b1;
      if (take_best) best_dist <= s_axis_tdata;
      if (take_idx)  best_idx  <= cur_idx;
      next_idx  <= idx_max ? cur_idx : cur_idx + INDEX_WIDTH'(1);
      match_cnt <= (hit && !cnt_max) ? cur_cnt + INDEX_WIDTH'(1) : cur_cnt;
      overflow  <= cur_ovf | idx_max | (hit & cnt_max);
    end
  end

  assign last_byte = (byte_ptr == PTR_W'(NBYTES - 1));
  assign handshake = (state == SEND) & m_axis_tready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (read_req) state_nxt = SEND;
      SEND:    if (handshake && last_byte) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                      byte_ptr <= '0;
    else if (state == IDLE && read_req) byte_ptr <= '0;
    else if (handshake)                byte_ptr <= byte_ptr + PTR_W'(1);
  end

  // Snapshot is pure data; it is only observable while in SEND, so it needs no reset.
  always_ff @(posedge aclk) begin
    if (state == IDLE && read_req)
      snap <= {match_cnt, best_idx, best_dist, best_valid, overflow, 6'b0};
  end

  assign snap_shift = snap >> {byte_ptr, 3'b000};

  always_comb begin
    m_axis_tvalid = (state == SEND);
    busy          = (state == SEND);
    m_axis_tlast  = (state == SEND) & last_byte;
    m_axis_tdata  = (state == SEND) ? snap_shift[7:0] : 8'h00;
  end

endmodule

// File: tb/tb_best_match_tracker.sv
// Randomised and directed bench for best_match_tracker: a history-queue model drives a per-cycle
// compare of two instances (INDEX_WIDTH 16 and 8); literal frames pin the model on the listed scenarios.
module tb_best_match_tracker;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic [7:0] threshold;
  logic       s_tvalid, s_tuser, read_req, m_tready;
  logic [7:0] s_tdata;
  logic [1:0] tv, tl, bz, bvv;
  logic [7:0] td [2];

  int checks = 0;
  int errors = 0;

  best_match_tracker #(.INDEX_WIDTH(16)) dut16 (
    .aclk(aclk), .aresetn(aresetn), .threshold(threshold),
    .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser),
    .read_req(read_req), .m_axis_tvalid(tv[0]), .m_axis_tready(m_tready),
    .m_axis_tdata(td[0]), .m_axis_tlast(tl[0]), .busy(bz[0]), .best_valid(bvv[0]));

  best_match_tracker #(.INDEX_WIDTH(8)) dut8 (
    .aclk(aclk), .aresetn(aresetn), .threshold(threshold),
    .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser),
    .read_req(read_req), .m_axis_tvalid(tv[1]), .m_axis_tready(m_tready),
    .m_axis_tdata(td[1]), .m_axis_tlast(tl[1]), .busy(bz[1]), .best_valid(bvv[1]));

  always #5 aclk = ~aclk;

`ifdef BEST_MATCH_TIE_LAST_EN
  localparam bit TIE_LAST = 1'b1;
`else
  localparam bit TIE_LAST = 1'b0;
`endif

  typedef struct {int d; bit hit;} beat_t;
  beat_t      hist[$];
  logic [7:0] exp_b [2][8];
  int         nb [2] = '{6, 4};
  int         wid [2] = '{16, 8};
  bit         sending [2];
  int         ptr [2];
  logic [7:0] got0[$], got1[$];

  task automatic chk(input int k, input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s[w%0d] actual=%0h required=%0h t=%0t", name, wid[k], act, req, $time);
    end
  endtask

  // Frame contents derived from the full history of the current search.
  task automatic build(input int k);
    int mx, bd, bi, hits;
    bit found, ovf;
    mx = (1 << wid[k]) - 1;
    bd = 255; bi = 0; hits = 0; found = 1'b0;
    foreach (hist[p]) begin
      if (!found || hist[p].d < bd || (TIE_LAST && hist[p].d == bd)) begin
        bd = hist[p].d;
        bi = (p > mx) ? mx : p;
      end
      found = 1'b1;
      if (hist[p].hit) hits++;
    end
    ovf = (hist.size() > mx) || (hits > mx);
    if (hits > mx) hits = mx;
    exp_b[k][0] = {found, ovf, 6'b0};
    exp_b[k][1] = 8'(bd);
    for (int b = 0; b < wid[k] / 8; b++) begin
      exp_b[k][2 + b]             = 8'((bi >> (8 * b)) & 255);
      exp_b[k][2 + wid[k] / 8 + b] = 8'((hits >> (8 * b)) & 255);
    end
  endtask

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      hist.delete();
      for (int k = 0; k < 2; k++) begin sending[k] = 1'b0; ptr[k] = 0; end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (sending[k]) begin
          if (m_tready) begin
            ptr[k]++;
            if (ptr[k] == nb[k]) sending[k] = 1'b0;
          end
        end else if (read_req) begin
          build(k);
          sending[k] = 1'b1;
          ptr[k] = 0;
        end
      end
      if (s_tvalid) begin
        if (s_tuser) hist.delete();
        hist.push_back('{d: int'(s_tdata), hit: (s_tdata <= threshold)});
      end
    end
  end

  logic [1:0] pv, pr;
  logic [7:0] pd [2];

  always @(negedge aclk) begin
    if (!aresetn) begin
      pv = 2'b00; pr = 2'b00;
    end else begin
      for (int k = 0; k < 2; k++) begin
        chk(k, "tvalid", int'(tv[k]), int'(sending[k]));
        chk(k, "busy", int'(bz[k]), int'(sending[k]));
        chk(k, "best_valid", int'(bvv[k]), int'(hist.size() > 0));
        if (sending[k]) begin
          chk(k, "tdata", int'(td[k]), int'(exp_b[k][ptr[k]]));
          chk(k, "tlast", int'(tl[k]), int'(ptr[k] == nb[k] - 1));
        end else begin
          chk(k, "tdata_idle", int'(td[k]), 0);
          chk(k, "tlast_idle", int'(tl[k]), 0);
        end
        if (pv[k] && !pr[k] && tv[k]) chk(k, "hold", int'(td[k]), int'(pd[k]));
        if (tv[k] && m_tready) begin
          if (k == 0) got0.push_back(td[k]);
          else        got1.push_back(td[k]);
        end
        pv[k] = tv[k]; pr[k] = m_tready; pd[k] = td[k];
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  task automatic beat(input bit u, input int d, input int t);
    s_tvalid = 1'b1; s_tuser = u; s_tdata = 8'(d); threshold = 8'(t);
    tick();
    s_tvalid = 1'b0; s_tuser = 1'b0;
  endtask

  // mode 1: tready pattern 1,0,0,1 and a second read_req while the frame is in flight
  task automatic do_read(input int mode);
    int j;
    got0.delete(); got1.delete();
    m_tready = 1'b1;
    read_req = 1'b1;
    tick();
    read_req = 1'b0;
    j = 0;
    while ((bz[0] || bz[1]) && j < 200) begin
      if (mode == 1) begin
        m_tready = (j % 4 == 0) || (j % 4 == 3);
        read_req = (j == 2);
      end
      tick();
      j++;
    end
    read_req = 1'b0;
    m_tready = 1'b1;
    chk(0, "frame_timeout", int'(j < 200), 1);
  endtask

  task automatic check_frame(input int k, input string name, input logic [63:0] e, input int n);
    int sz;
    sz = (k == 0) ? got0.size() : got1.size();
    chk(k, {name, "_len"}, sz, n);
    for (int i = 0; i < n && i < sz; i++)
      chk(k, $sformatf("%s_b%0d", name, i), int'((k == 0) ? got0[i] : got1[i]),
          int'(e[8 * (n - 1 - i) +: 8]));
  endtask

  initial begin
    aresetn = 1'b0; threshold = 8'd0; s_tvalid = 1'b0; s_tuser = 1'b0;
    s_tdata = 8'd0; read_req = 1'b0; m_tready = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk(k, "rst_tvalid", int'(tv[k]), 0);
      chk(k, "rst_busy", int'(bz[k]), 0);
      chk(k, "rst_tlast", int'(tl[k]), 0);
      chk(k, "rst_tdata", int'(td[k]), 0);
      chk(k, "rst_best_valid", int'(bvv[k]), 0);
    end
    repeat (3) tick();
    aresetn = 1'b1;
    tick();

    do_read(0);
    check_frame(0, "empty", 64'h00FF00000000, 6);
    check_frame(1, "empty", 64'h00FF0000, 4);

    beat(1, 5, 4); beat(0, 3, 4); beat(0, 7, 4); beat(0, 3, 4);
    do_read(0);
    check_frame(0, "basic", TIE_LAST ? 64'h800303000200 : 64'h800301000200, 6);
    check_frame(1, "basic", TIE_LAST ? 64'h80030302 : 64'h80030102, 4);

    do_read(1);
    check_frame(0, "stall", TIE_LAST ? 64'h800303000200 : 64'h800301000200, 6);
    check_frame(1, "stall", TIE_LAST ? 64'h80030302 : 64'h80030102, 4);
    repeat (5) tick();
    chk(0, "no_requeue_len", got0.size(), 6);
    chk(0, "no_requeue_busy", int'(bz[0]), 0);

    beat(1, 9, 2);
    do_read(0);
    check_frame(0, "clear", 64'h800900000000, 6);
    check_frame(1, "clear", 64'h80090000, 4);

    beat(1, 1, 1);
    repeat (299) beat(0, 1, 1);
    do_read(0);
    check_frame(0, "sat", TIE_LAST ? 64'h80012B012C01 : 64'h800100002C01, 6);
    check_frame(1, "sat", TIE_LAST ? 64'hC001FFFF : 64'hC00100FF, 4);

    m_tready = 1'b0;
    read_req = 1'b1;
    tick();
    read_req = 1'b0;
    tick();
    chk(0, "pre_rst_tvalid", int'(tv[0]), 1);
    aresetn = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk(k, "async_tvalid", int'(tv[k]), 0);
      chk(k, "async_busy", int'(bz[k]), 0);
      chk(k, "async_tlast", int'(tl[k]), 0);
      chk(k, "async_tdata", int'(td[k]), 0);
      chk(k, "async_best_valid", int'(bvv[k]), 0);
    end
    tick();
    aresetn = 1'b1;
    m_tready = 1'b1;
    tick();

    for (int c = 0; c < 3000; c++) begin
      s_tvalid  = ($urandom_range(0, 3) != 0);
      s_tuser   = ($urandom_range(0, 15) == 0);
      s_tdata   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      threshold = 8'($urandom_range(0, 15));
      read_req  = ($urandom_range(0, 19) == 0);
      m_tready  = ($urandom_range(0, 2) != 0);
      tick();
    end
    s_tvalid = 1'b0; read_req = 1'b0; m_tready = 1'b1;
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
